alu_ctrl_decoder: RTL and testbench

ALU_CTRL_DECODER -- requirements
Module: alu_ctrl_decoder

---
 rtl/alu_ctrl_decoder_if.sv | 40 ++++
 rtl/alu_ctrl_decoder.sv | 176 +++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_decoder_if.sv
// Handshake/bus bundle between the instruction source, the RV32I ALU-control decoder and the
// ALU stage that consumes decoded instructions.
//   master : environment side; drives in_valid/in_instr/out_ready and observes the rest.
//   slave  : decoder side; accepts instructions and presents decoded fields.
// Signals:
//   in_valid/in_ready/in_instr     - instruction input handshake and 32-bit word
//   out_valid/out_ready            - decoded output handshake
//   out_alu_ctrl, out_rs1/rs2/rd,
//   out_imm, out_use_imm,
//   out_illegal                    - decoded fields of the head entry
//   illegal_cnt                    - saturating count of accepted illegal instructions
interface alu_ctrl_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_alu_ctrl;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [31:0]      out_imm;
  logic             out_use_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_alu_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
           out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_alu_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
           out_illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// RV32I ALU-control decoder with a two-entry skid buffer on its output.
// Instructions are decoded combinationally and registered at acceptance, so decoded fields come
// straight from flops. in_ready depends only on buffer occupancy, never on out_ready.
// Ports:
//   clk    - clock, all state on rising edge
//   rst_n  - asynchronous active-low reset; empties the buffer and clears the counter
//   bus    - alu_ctrl_decoder_if slave modport (handshakes, decoded fields, illegal_cnt)
// Configuration:
//   ALU_DEC_IMM_EN - when defined, OP-IMM instructions are decoded; otherwise they are illegal
//                    and out_use_imm is always 0.
module alu_ctrl_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_ctrl_decoder_if.slave bus
);

  localparam logic [3:0] AluNone = 4'b0000;
  localparam logic [3:0] AluAdd  = 4'b0001;
  localparam logic [3:0] AluSub  = 4'b0010;
  localparam logic [3:0] AluSll  = 4'b0011;
  localparam logic [3:0] AluSlt  = 4'b0100;
  localparam logic [3:0] AluXor  = 4'b0101;
  localparam logic [3:0] AluSrl  = 4'b0110;
  localparam logic [3:0] AluSra  = 4'b0111;
  localparam logic [3:0] AluOr   = 4'b1000;
  localparam logic [3:0] AluAnd  = 4'b1001;

  typedef struct packed {
    logic [3:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  dec_t             head_q, head_d;
  dec_t             tail_q, tail_d;
  dec_t             dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // Decode of the word currently offered on in_instr.
  always_comb begin
    dec     = '0;
    dec.rs1 = bus.in_instr[19:15];
    dec.rs2 = bus.in_instr[24:20];
    dec.rd  = bus.in_instr[11:7];
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  dec.alu = AluAdd;
            3'b001:  dec.alu = AluSll;
            3'b010:  dec.alu = AluSlt;
            3'b100:  dec.alu = AluXor;
            3'b101:  dec.alu = AluSrl;
            3'b110:  dec.alu = AluOr;
            3'b111:  dec.alu = AluAnd;
            default: dec.alu = AluNone;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) dec.alu = AluSub;
          else if (funct3 == 3'b101) dec.alu = AluSra;
        end
      end
`ifdef ALU_DEC_IMM_EN
      7'b0010011: begin
        dec.imm = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        case (funct3)
          3'b000:  dec.alu = AluAdd;
          3'b010:  dec.alu = AluSlt;
          3'b100:  dec.alu = AluXor;
          3'b110:  dec.alu = AluOr;
          3'b111:  dec.alu = AluAnd;
          3'b001:  if (funct7 == 7'b0000000) dec.alu = AluSll;
          3'b101: begin
            if (funct7 == 7'b0000000) dec.alu = AluSrl;
            else if (funct7 == 7'b0100000) dec.alu = AluSra;
          end
          default: dec.alu = AluNone;
        endcase
        // Shifts take only the shamt field as the immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101) dec.imm = {27'b0, bus.in_instr[24:20]};
        dec.use_imm = 1'b1;
        dec.rs2     = 5'd0;
      end
`endif
      default: dec.alu = AluNone;
    endcase
    // Anything that did not resolve to an ALU op reports raw register fields only.
    if (dec.alu == AluNone) begin
      dec.imm     = '0;
      dec.use_imm = 1'b0;
      dec.rs2     = bus.in_instr[24:20];
      dec.illegal = 1'b1;
    end
  end

  assign bus.in_ready  = (state_q != StTwo);
  assign bus.out_valid = (state_q != StEmpty);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Head always feeds the outputs; tail only holds the second entry while the consumer stalls.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    case (state_q)
      StEmpty: begin
        if (push) begin
          state_d = StOne;
          head_d  = dec;
        end
      end
      StOne: begin
        case ({push, pop})
          2'b10: begin
            state_d = StTwo;
            tail_d  = dec;
          end
          2'b01:   state_d = StEmpty;
          2'b11:   head_d  = dec;
          default: state_d = StOne;
        endcase
      end
      StTwo: begin
        if (pop) begin
          state_d = StOne;
          head_d  = tail_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (push && dec.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_alu_ctrl = head_q.alu;
  assign bus.out_rs1      = head_q.rs1;
  assign bus.out_rs2      = head_q.rs2;
  assign bus.out_rd       = head_q.rd;
  assign bus.out_imm      = head_q.imm;
  assign bus.out_use_imm  = head_q.use_imm;
  assign bus.out_illegal  = head_q.illegal;
  assign bus.illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: directed steps plus randomized traffic, checked
// against a queue-based reference model that decodes from instruction-set rules.
module tb_alu_ctrl_decoder;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  alu_ctrl_decoder_if #(.CNT_W(CNT_W)) bus_if ();

  alu_ctrl_decoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   cnt_m;
  int   checks;
  int   errors;

  // ALU codes for funct7 = 0 by funct3; 0 marks a hole (sltu/sltiu).
  int op_tab [8] = '{1, 3, 4, 0, 5, 6, 8, 9};

  function automatic exp_t ref_decode(logic [31:0] ins);
    exp_t       e;
    int         code;
    int         s;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opc       = ins[6:0];
    f7        = ins[31:25];
    f3        = ins[14:12];
    code      = 0;
    e.rs1     = ins[19:15];
    e.rs2     = ins[24:20];
    e.rd      = ins[11:7];
    e.imm     = 32'd0;
    e.use_imm = 1'b0;
    if (opc == 7'h33) begin
      if (f7 == 7'h00) code = op_tab[f3];
      else if (f7 == 7'h20) code = (f3 == 3'd0) ? 2 : (f3 == 3'd5) ? 7 : 0;
    end
`ifdef ALU_DEC_IMM_EN
    else if (opc == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00) code = op_tab[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) code = 7;
        if (code != 0) e.imm = {27'd0, ins[24:20]};
      end else begin
        code = op_tab[f3];
        s = $signed(ins[31:20]);
        if (code != 0) e.imm = s;
      end
      if (code != 0) begin
        e.use_imm = 1'b1;
        e.rs2     = 5'd0;
      end
    end
`endif
    e.alu     = code;
    e.illegal = (code == 0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    int c;
    c = (cnt_m > CNT_MAX) ? CNT_MAX : cnt_m;
    chk("in_ready", 32'(bus_if.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus_if.out_valid), 32'(q.size() > 0));
    chk("illegal_cnt", 32'(bus_if.illegal_cnt), c);
    if (q.size() > 0) begin
      chk("alu_ctrl", 32'(bus_if.out_alu_ctrl), q[0].alu);
      chk("rs1", 32'(bus_if.out_rs1), 32'(q[0].rs1));
      chk("rs2", 32'(bus_if.out_rs2), 32'(q[0].rs2));
      chk("rd", 32'(bus_if.out_rd), 32'(q[0].rd));
      chk("imm", bus_if.out_imm, q[0].imm);
      chk("use_imm", 32'(bus_if.out_use_imm), 32'(q[0].use_imm));
      chk("illegal", 32'(bus_if.out_illegal), 32'(q[0].illegal));
    end
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(bus_if.illegal_cnt), 32'd0);
    chk({tag, "_alu"}, 32'(bus_if.out_alu_ctrl), 32'd0);
    chk({tag, "_regs"}, 32'({bus_if.out_rs1, bus_if.out_rs2, bus_if.out_rd}), 32'd0);
    chk({tag, "_imm"}, bus_if.out_imm, 32'd0);
    chk({tag, "_flags"}, 32'({bus_if.out_use_imm, bus_if.out_illegal}), 32'd0);
  endtask

  // One clock cycle: drive, let the edge happen, advance the model, check mid-cycle.
  task automatic cycle(logic v, logic [31:0] ins, logic rdy);
    bit acc, pop;
    bus_if.in_valid  = v;
    bus_if.in_instr  = ins;
    bus_if.out_ready = rdy;
    @(posedge clk);
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (acc) begin
      exp_t e;
      e = ref_decode(ins);
      q.push_back(e);
      if (e.illegal) cnt_m++;
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] f7;
    logic [6:0] opc;
    int         k;
    k   = $urandom_range(0, 3);
    f7  = ($urandom_range(0, 2) == 0) ? 7'h20 : ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h00;
    opc = (k == 0) ? 7'h33 : (k == 1) ? 7'h13 : 7'($urandom);
    if (k == 3) return 32'h0020B1B3;
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  initial begin
    checks           = 0;
    errors           = 0;
    cnt_m            = 0;
    rst_n            = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_instr  = 32'd0;
    bus_if.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset("rst_during");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst_after");

    // add x3,x1,x2 with one cycle latency
    cycle(1'b1, 32'h002081B3, 1'b0);
    chk("add_alu", 32'(bus_if.out_alu_ctrl), 32'h1);
    chk("add_fields", 32'({bus_if.out_rs1, bus_if.out_rs2, bus_if.out_rd}), 32'({5'd1, 5'd2, 5'd3}));
    cycle(1'b0, 32'd0, 1'b1);

    // sub then sra in order
    cycle(1'b1, 32'h40208133, 1'b1);
    chk("sub_alu", 32'(bus_if.out_alu_ctrl), 32'h2);
    cycle(1'b1, 32'h4020D133, 1'b1);
    chk("sra_alu", 32'(bus_if.out_alu_ctrl), 32'h7);
    cycle(1'b0, 32'd0, 1'b1);

    // addi x1,x0,-1
    cycle(1'b1, 32'hFFF00093, 1'b1);
`ifdef ALU_DEC_IMM_EN
    chk("addi_imm", bus_if.out_imm, 32'hFFFFFFFF);
    chk("addi_use_imm", 32'(bus_if.out_use_imm), 32'd1);
`else
    chk("addi_illegal", 32'(bus_if.out_illegal), 32'd1);
    chk("addi_cnt", 32'(bus_if.illegal_cnt), 32'd1);
`endif
    cycle(1'b0, 32'd0, 1'b1);

    // Stall: three offered, two accepted, outputs stable, then drain in order
    cycle(1'b1, 32'h002081B3, 1'b0);
    cycle(1'b1, 32'h40208133, 1'b0);
    cycle(1'b1, 32'h0020C1B3, 1'b0);
    chk("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
    cycle(1'b1, 32'h0020C1B3, 1'b0);
    cycle(1'b1, 32'h0020C1B3, 1'b1);
    cycle(1'b1, 32'h0020C1B3, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

    // 300 sltu: all illegal, counter saturates
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 32'h0020B1B3, 1'b1);
      chk("sltu_alu", 32'(bus_if.out_alu_ctrl), 32'd0);
    end
    chk("sat_cnt", 32'(bus_if.illegal_cnt), 32'(CNT_MAX));

    // Asynchronous reset mid-stream with a full buffer
    cycle(1'b1, 32'h0020B1B3, 1'b0);
    cycle(1'b1, 32'h0020B1B3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    q.delete();
    cnt_m           = 0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h002081B3, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
